result_drain: RTL and testbench
===============================

# result_drain

Output-side collector for the matrix multiplier. It captures the per-element results emitted by the final data register (one truncated `DATA_WIDTH` value plus an invalid/overflow flag per strobe) into a frame buffer of `MAT_DIM*MAT_DIM` entries. Once the frame is complete, it streams the results out in capture order over a valid/ready interface. It is the consumer end of the final-data interface and sits between the datapath and the host-facing output port.

## Interface
- `DATA_WIDTH`, 8, result element width.
- `MAT_DIM`, 2, matrix dimension; frame size `N = MAT_DIM*MAT_DIM`; `N >= 2`.

- `clk` in 1: single clock, rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `res_valid` in 1: capture strobe, one element per high cycle.
- `res_data` in `DATA_WIDTH`: result value; may be X/Z when `res_invalid=1`.
- `res_invalid` in 1: element overflowed; may be X/Z while `res_valid=0`.
- `collect_ready` out 1: block is in COLLECT and can accept a strobe.
- `out_valid` out 1: `out_data`/`out_invalid`/`out_last` hold a valid element.
- `out_ready` in 1: downstream accepts the element.
- `out_data` out `DATA_WIDTH`: element value.
- `out_invalid` out 1: element flagged overflowed.
- `out_last` out 1: element is index `N-1` of the frame.
- `frame_done` out 1: one-cycle pulse after the last output handshake.
- `drop_err` out 1: sticky error, a strobe arrived while not collecting.
- `clr_err` in 1: synchronous clear of `drop_err`.

## Operation
- FSM has two states.
  - COLLECT: on `res_valid`, write entry `wr_cnt` and increment `wr_cnt`. When `wr_cnt == N-1` is written, clear `wr_cnt` and go to DRAIN.
  - DRAIN: `out_valid=1`, and outputs show entry `rd_cnt`. On `out_valid && out_ready`, increment `rd_cnt`. The handshake at `rd_cnt == N-1` clears `rd_cnt`, pulses `frame_done`, and returns to COLLECT.
- Capture sanitising: when `res_invalid=1`, store data `0` and flag `1`, ignoring `res_data` entirely (no X/Z propagates into the buffer). Otherwise store `res_data` and flag `0`.
- Only the value `1'b1` on `res_invalid` counts as invalid. X/Z on `res_invalid` while `res_valid=1` is a protocol violation and is flagged by an assertion.
- `res_valid` in DRAIN: the element is dropped, `drop_err` is set, and the state is unchanged.
- `clr_err` and a new drop in the same cycle: set wins.
- `out_last = (state==DRAIN) && (rd_cnt == N-1)`.
- While `out_valid=1` and `out_ready=0`, the outputs hold stable.
- Reset mid-frame discards partial capture and pending drain. There is no recovery.

## Timing
- Reset values:
  - state COLLECT, `wr_cnt=rd_cnt=0`
  - `collect_ready=1`
  - `out_valid=0`, `out_data=0`, `out_invalid=0`, `out_last=0`
  - `frame_done=0`, `drop_err=0`
  - buffer contents don't-care, but must not reach the outputs while `out_valid=0`; outputs read 0 then.
- All outputs are driven from registers, with no combinational path from inputs to outputs.
- Latency: the last element is captured at edge k. `out_valid` and entry 0 are visible after edge k.
- Throughput: one element per cycle with `out_ready` held high. A full frame drains in N cycles.
- `frame_done` is high for the single cycle after the final handshake edge. `collect_ready` is 1 in that same cycle.
- A capture accepted in the first COLLECT cycle after DRAIN is legal; there is no dead cycle.

## Configuration
- `RESULT_DRAIN_SAT_EN` defined: invalid elements are stored and output as all-ones (`{DATA_WIDTH{1'b1}}`), with `out_invalid=1`.
- `RESULT_DRAIN_SAT_EN` undefined: invalid elements are stored and output as 0, with `out_invalid=1`.
- The macro changes no other behaviour.

## Structure
- Shared package `mm_pkg`:
  - state enum `drain_state_t` {COLLECT, DRAIN}
  - localparam helper for `N` and the counter width `$clog2(N)`
- Sub-module `result_buf`: N x (`DATA_WIDTH`+1) register array with one write port and one registered read port, async-reset-free storage.
- The FSM, counters, sanitising and error logic live in `result_drain`.

## Test plan
All scenarios use `DATA_WIDTH=8`, `MAT_DIM=2`.
- Four strobes with data 0x01, 0x22, 0x7E, 0x10, `out_ready=1` -> out_data 0x01, 0x22, 0x7E, 0x10 on consecutive cycles; `out_last` only on 0x10; `frame_done` one cycle later.
- Second strobe `res_invalid=1` with `res_data=8'bz` -> element 1 reads data 0x00 and `out_invalid=1`. With `RESULT_DRAIN_SAT_EN` defined, it reads 0xFF with `out_invalid=1`. No X appears on the outputs.
- Full frame, `out_ready` toggling 1,0,0,1,... -> outputs stable during stalls; order preserved; exactly four handshakes.
- Strobe during DRAIN -> `drop_err=1`, frame contents unchanged. Then `clr_err` -> 0. Then `clr_err` together with a drop in the same cycle -> stays 1.
- `reset_n` low after 3 captures -> all outputs at reset values. After release, 4 fresh captures drain correctly with no stale data.
- Back-to-back frames: the first capture of frame 2 in the cycle of the `frame_done` pulse -> accepted; frame 2 drains intact.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: shared types and sizing helpers for the matrix-multiplier output path.
package mm_pkg;

  // Result collector states: filling the frame buffer, or streaming it out.
  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } drain_state_t;

  // Smallest matrix dimension the collector supports (frame of at least 2).
  localparam int MIN_MAT_DIM = 2;

  // Number of elements in one result frame.
  function automatic int frame_n(input int mat_dim);
    return mat_dim * mat_dim;
  endfunction

  // Width of a counter indexing a frame of n elements.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_buf.sv
// result_buf: frame storage for result_drain. One synchronous write port and
// one registered read port; no reset on the array or the read register.
module result_buf #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port: store one element per enabled cycle.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: registered read of the requested entry every cycle.
  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/result_drain.sv
// result_drain: captures one matrix-multiplier result frame (N = MAT_DIM^2
// elements, each a value plus an overflow flag) and streams it out in capture
// order over valid/ready.
// Build option: RESULT_DRAIN_SAT_EN -- when defined, overflowed elements are
// stored as all-ones instead of zero.
module result_drain
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAT_DIM    = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  input  logic                  res_invalid,
  output logic                  collect_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_invalid,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  drop_err,
  input  logic                  clr_err
);

  localparam int N  = frame_n(MAT_DIM);
  localparam int CW = cnt_w(N);
  localparam int EW = DATA_WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef RESULT_DRAIN_SAT_EN
  localparam logic [DATA_WIDTH-1:0] INV_DATA = {DATA_WIDTH{1'b1}};
`else
  localparam logic [DATA_WIDTH-1:0] INV_DATA = '0;
`endif

  drain_state_t    r_state, w_state_nxt;
  logic [CW-1:0]   r_wr_cnt, w_wr_cnt_nxt;
  logic [CW-1:0]   r_rd_cnt, w_rd_cnt_nxt;
  logic            w_capture;
  logic            w_drop;
  logic            w_last_hs;
  logic [EW-1:0]   w_wr_elem;
  logic [EW-1:0]   w_rd_elem;
  logic            r_frame_done;
  logic            r_drop_err;

  // Next-state, counter and event decode for the collect/drain FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_cnt_nxt = r_wr_cnt;
    w_rd_cnt_nxt = r_rd_cnt;
    w_capture    = 1'b0;
    w_drop       = 1'b0;
    w_last_hs    = 1'b0;
    case (r_state)
      COLLECT: begin
        if (res_valid) begin
          w_capture = 1'b1;
          if (r_wr_cnt == LAST_IDX) begin
            w_wr_cnt_nxt = '0;
            w_state_nxt  = DRAIN;
          end else begin
            w_wr_cnt_nxt = r_wr_cnt + CNT_ONE;
          end
        end
      end
      DRAIN: begin
        // Strobes here have nowhere to go; they are discarded and flagged.
        w_drop = res_valid;
        if (out_ready) begin
          if (r_rd_cnt == LAST_IDX) begin
            w_rd_cnt_nxt = '0;
            w_state_nxt  = COLLECT;
            w_last_hs    = 1'b1;
          end else begin
            w_rd_cnt_nxt = r_rd_cnt + CNT_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = COLLECT;
      end
    endcase
  end

  // Sanitise the incoming element: an overflowed result never stores res_data.
  always_comb begin
    w_wr_elem = {1'b0, res_data};
    if (res_invalid == 1'b1) w_wr_elem = {1'b1, INV_DATA};
  end

  // FSM state and frame counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= COLLECT;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_cnt <= w_wr_cnt_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
    end
  end

  // End-of-frame pulse and sticky drop error (a new drop beats a clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done <= 1'b0;
      r_drop_err   <= 1'b0;
    end else begin
      r_frame_done <= w_last_hs;
      if (w_drop)       r_drop_err <= 1'b1;
      else if (clr_err) r_drop_err <= 1'b0;
    end
  end

  // The read address follows the next read count, so the registered read
  // port already holds the element the outputs must show after each edge.
  result_buf #(
    .WIDTH (EW),
    .DEPTH (N),
    .AW    (CW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_capture),
    .i_waddr (r_wr_cnt),
    .i_wdata (w_wr_elem),
    .i_raddr (w_rd_cnt_nxt),
    .o_rdata (w_rd_elem)
  );

  // Outputs decode registered state only; buffer contents are masked to zero
  // whenever no element is being offered.
  assign collect_ready = (r_state == COLLECT);
  assign out_valid     = (r_state == DRAIN);
  assign out_data      = out_valid ? w_rd_elem[DATA_WIDTH-1:0] : '0;
  assign out_invalid   = out_valid & w_rd_elem[DATA_WIDTH];
  assign out_last      = out_valid && (r_rd_cnt == LAST_IDX);
  assign frame_done    = r_frame_done;
  assign drop_err      = r_drop_err;

  // An accepted strobe must carry a known overflow flag.
  a_res_invalid_known: assert property (
    @(posedge clk) disable iff (!reset_n) res_valid |-> !$isunknown(res_invalid)
  );

endmodule

// File: tb/tb_result_drain.sv
module tb_result_drain;

  localparam int DW = 8;
  localparam int MD = 2;
  localparam int N  = MD * MD;

`ifdef RESULT_DRAIN_SAT_EN
  localparam logic [DW-1:0] INV_VAL = {DW{1'b1}};
`else
  localparam logic [DW-1:0] INV_VAL = '0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic          inv;
    logic          last;
  } elem_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          res_valid = 1'b0;
  logic [DW-1:0] res_data = '0;
  logic          res_invalid = 1'b0;
  logic          out_ready = 1'b0;
  logic          clr_err = 1'b0;
  logic          collect_ready, out_valid, out_invalid, out_last, frame_done, drop_err;
  logic [DW-1:0] out_data;

  int n_chk = 0;
  int n_fail = 0;

  elem_t obs_q[$];
  elem_t exp_q[$];
  elem_t part_q[$];
  int    unstable_cnt = 0;
  bit    prev_stall = 0;
  elem_t prev_out;

  always #5 clk = ~clk;

  result_drain #(.DATA_WIDTH(DW), .MAT_DIM(MD)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_invalid   (res_invalid),
    .collect_ready (collect_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_invalid   (out_invalid),
    .out_last      (out_last),
    .frame_done    (frame_done),
    .drop_err      (drop_err),
    .clr_err       (clr_err)
  );

  // Output monitor on the inactive edge: records handshakes, tracks stall stability.
  always @(negedge clk) begin
    elem_t cur;
    cur = '{d: out_data, inv: out_invalid, last: out_last};
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!out_valid || cur !== prev_out)) unstable_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
      if (out_valid && out_ready) obs_q.push_back(cur);
    end
  end

  // Reference model: a frame is the next N accepted captures, emitted in order.
  task automatic model_add(input logic [DW-1:0] d, input logic inv);
    elem_t e;
    e.d    = inv ? INV_VAL : d;
    e.inv  = inv;
    e.last = (part_q.size() == N - 1);
    part_q.push_back(e);
    if (part_q.size() == N) begin
      exp_q = {exp_q, part_q};
      part_q.delete();
    end
  endtask

  // One strobe (called at posedge+1); returns at the following posedge+1.
  task automatic strobe(input logic [DW-1:0] d, input logic inv);
    res_valid   = 1'b1;
    res_invalid = inv;
    if (inv) res_data = {DW{1'bz}};
    else     res_data = d;
    @(posedge clk); #1;
    res_valid   = 1'b0;
    res_invalid = 1'b0;
    res_data    = '0;
  endtask

  task automatic cap(input logic [DW-1:0] d, input logic inv);
    strobe(d, inv);
    model_add(d, inv);
  endtask

  // Drive out_ready (0: held high, 1: 1,0,0 repeating, 2: random) until frame_done.
  task automatic drain(input int mode, output bit ok);
    ok = 0;
    for (int c = 0; c < 64; c++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((c % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      if (frame_done) begin ok = 1; break; end
    end
    out_ready = 1'b0;
  endtask

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
    part_q.delete();
    unstable_cnt = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_chk++;
    if ({collect_ready, out_valid, out_data, out_invalid, out_last, frame_done, drop_err}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got cr=%b v=%b d=%h i=%b l=%b fd=%b de=%b want 1 0 00 0 0 0 0",
               collect_ready, out_valid, out_data, out_invalid, out_last, frame_done, drop_err);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] vals [N];
    vals[0] = 8'h01; vals[1] = 8'h22; vals[2] = 8'h7E; vals[3] = 8'h10;
    clear_queues();
    for (int i = 0; i < N; i++) cap(vals[i], 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      n_chk++;
      if ({out_valid, collect_ready, out_data, out_invalid, out_last, frame_done}
          !== {1'b1, 1'b0, vals[i], 1'b0, (i == N - 1), 1'b0}) begin
        n_fail++;
        $display("FAIL basic_cycle%0d: got v=%b cr=%b d=%h i=%b l=%b fd=%b want 1 0 %h 0 %b 0",
                 i, out_valid, collect_ready, out_data, out_invalid, out_last, frame_done,
                 vals[i], (i == N - 1));
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    n_chk++;
    if ({frame_done, collect_ready, out_valid, out_data, out_last} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_done: got fd=%b cr=%b v=%b d=%h l=%b want 1 1 0 00 0",
               frame_done, collect_ready, out_valid, out_data, out_last);
    end
    @(posedge clk); #1;
    n_chk++;
    if (frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: got %b want 0", frame_done);
    end
  endtask

  task automatic test_invalid();
    bit ok;
    clear_queues();
    cap(8'h11, 1'b0);
    cap(8'hA5, 1'b1);
    cap(8'h33, 1'b0);
    cap(8'h44, 1'b0);
    drain(0, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL invalid_timeout: got no frame_done want frame_done"); end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL invalid_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL invalid_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_queues();
    for (int i = 0; i < N; i++) cap(8'($urandom), 1'b0);
    drain(1, ok);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL stall_timeout: got no frame_done want frame_done"); end
    n_chk++;
    if (obs_q.size() != N) begin
      n_fail++;
      $display("FAIL stall_handshakes: got %0d want %0d", obs_q.size(), N);
    end
    n_chk++;
    if (unstable_cnt != 0) begin
      n_fail++;
      $display("FAIL stall_stable: got %0d changes while stalled want 0", unstable_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_drop();
    bit ok;
    clear_queues();
    for (int i = 0; i < N; i++) cap(8'($urandom), 1'b0);
    n_chk++;
    if (drop_err !== 1'b0) begin n_fail++; $display("FAIL drop_initial: got %b want 0", drop_err); end
    strobe(8'hEE, 1'b0);
    n_chk++;
    if ({drop_err, out_valid, out_data} !== {1'b1, 1'b1, exp_q[0].d}) begin
      n_fail++;
      $display("FAIL drop_set: got de=%b v=%b d=%h want 1 1 %h", drop_err, out_valid, out_data, exp_q[0].d);
    end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    n_chk++;
    if (drop_err !== 1'b0) begin n_fail++; $display("FAIL drop_clear: got %b want 0", drop_err); end
    clr_err = 1'b1;
    strobe(8'h5A, 1'b0);
    clr_err = 1'b0;
    n_chk++;
    if (drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_set_wins: got %b want 1", drop_err); end
    drain(0, ok);
    n_chk++;
    if (!ok || obs_q.size() != N) begin
      n_fail++;
      $display("FAIL drop_drain: got done=%0d count=%0d want 1 %0d", ok, obs_q.size(), N);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL drop_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_queues();
    for (int i = 0; i < 3; i++) cap(8'($urandom), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    part_q.delete();
    n_chk++;
    if ({collect_ready, out_valid, out_data, out_invalid, out_last, frame_done, drop_err}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_outputs: got cr=%b v=%b d=%h i=%b l=%b fd=%b de=%b want 1 0 00 0 0 0 0",
               collect_ready, out_valid, out_data, out_invalid, out_last, frame_done, drop_err);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) cap(8'($urandom), ($urandom_range(0, 3) == 0));
    drain(2, ok);
    n_chk++;
    if (!ok || obs_q.size() != N) begin
      n_fail++;
      $display("FAIL midreset_drain: got done=%0d count=%0d want 1 %0d", ok, obs_q.size(), N);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midreset_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    clear_queues();
    for (int i = 0; i < N; i++) cap(8'($urandom), 1'b0);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 32 && !seen; c++) begin
      @(posedge clk); #1;
      seen = frame_done;
    end
    n_chk++;
    if (!seen || collect_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done_cycle: got fd=%0d cr=%b want 1 1", seen, collect_ready);
    end
    for (int i = 0; i < N; i++) cap(8'($urandom), ($urandom_range(0, 3) == 0));
    drain(0, ok);
    n_chk++;
    if (!ok || obs_q.size() != 2 * N) begin
      n_fail++;
      $display("FAIL b2b_drain: got done=%0d count=%0d want 1 %0d", ok, obs_q.size(), 2 * N);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_queues();
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) begin
        cap(8'($urandom), ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
      end
      drain(2, ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL random_timeout%0d: got no frame_done want frame_done", f); end
    end
    n_chk++;
    if (unstable_cnt != 0) begin
      n_fail++;
      $display("FAIL random_stable: got %0d changes while stalled want 0", unstable_cnt);
    end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_elem%0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_stall();
    test_drop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
